// File: rtl/mn_ff_bank_arbiter.sv
// mn_ff_bank_arbiter: round-robin sequencer sharing a bank of negedge M/N flops among requesters.
// Define MN_ARB_VERIFY_EN to add the sticky readback-check output err.
module mn_ff_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = $clog2(NUM_FF)
) (
  input  logic                     clk,
  input  logic                     CLRn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op,
  input  logic [IDX_W*NUM_REQ-1:0] idx,
  input  logic [NUM_FF-1:0]        q_in,
  output logic [NUM_FF-1:0]        m_out,
  output logic [NUM_FF-1:0]        n_out,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rdata,
  output logic                     busy
`ifdef MN_ARB_VERIFY_EN
  , output logic                   err
`endif
);
  localparam int RW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] rr_q, rr_d, win_q, win_d, win, c;
  logic [1:0] op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_FF-1:0] m_q, m_d, n_q, n_d, sel;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, req_m;
  logic mask_q, mask_d, rdata_q, rdata_d, busy_q, busy_d, hit, launch;
  logic [1:0] op_a [NUM_REQ];
  logic [IDX_W-1:0] idx_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g]  = op[2*g +: 2];
    assign idx_a[g] = idx[IDX_W*g +: IDX_W];
  end
  always_ff @(posedge clk or posedge CLRn)
    if (CLRn) state_q <= IDLE;
    else state_q <= state_d;
  // The previous winner is masked for one IDLE cycle so a slow deassert cannot double-grant.
  always_comb begin
    req_m = req & ~(mask_q ? (NUM_REQ'(1) << win_q) : '0);
    win = '0;
    c = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      c = RW'((int'(rr_q) + j) % NUM_REQ);
      win = req_m[c] ? c : win;
    end
    launch = state_q == IDLE && |req_m;
    state_d = launch ? APPLY : state_q == APPLY ? ACK : IDLE;
  end
  always_comb begin
    win_d = launch ? win : win_q;
    op_d = launch ? op_a[win] : op_q;
    idx_d = launch ? idx_a[win] : idx_q;
    for (int i = 0; i < NUM_FF; i++) sel[i] = idx_d == IDX_W'(i);
    hit = |(q_in & sel);
    m_d = launch ? ~sel | {NUM_FF{op_d[1]}} : '1;
    n_d = launch ? ~sel | {NUM_FF{op_d[0]}} : '1;
    gnt_d = state_q == APPLY ? NUM_REQ'(1) << win_q : '0;
    rdata_d = state_q == APPLY && hit;
    busy_d = state_d != IDLE;
    mask_d = state_q == ACK;
    rr_d = state_q == ACK ? (win_q == RW'(NUM_REQ - 1) ? '0 : win_q + 1'b1) : rr_q;
  end
  always_ff @(posedge clk or posedge CLRn)
    if (CLRn) begin
      rr_q    <= '0;
      win_q   <= '0;
      op_q    <= 2'b11;
      idx_q   <= '0;
      mask_q  <= 1'b0;
      m_q     <= '1;
      n_q     <= '1;
      gnt_q   <= '0;
      rdata_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      m_q     <= m_d;
      n_q     <= n_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  assign m_out = m_q;
  assign n_out = n_q;
  assign gnt   = gnt_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
`ifdef MN_ARB_VERIFY_EN
  logic pre_q, pre_d, err_q, err_d, exp_v;
  always_comb begin
    pre_d = state_q == IDLE ? hit : pre_q;
    exp_v = op_q == 2'b01 ? 1'b1 : op_q == 2'b10 ? 1'b0 : op_q == 2'b11 ? pre_q : ~pre_q;
    err_d = err_q | (state_q == APPLY && |sel && hit != exp_v);
  end
  always_ff @(posedge clk or posedge CLRn)
    if (CLRn) begin
      pre_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      err_q <= err_d;
    end
  assign err = err_q;
`endif
endmodule

// File: tb/tb_mn_ff_bank_arbiter.sv
// tb_mn_ff_bank_arbiter: scoreboard bench for mn_ff_bank_arbiter driving a behavioural M/N flop bank.
// IDX_W is widened to 4 so an out-of-range target index can be requested.
module tb_mn_ff_bank_arbiter;
  localparam int NR = 4, NF = 8, IW = 4;
  logic clk = 1'b0, CLRn = 1'b1;
  logic [NR-1:0] req = '0;
  logic [2*NR-1:0] op = '0;
  logic [IW*NR-1:0] idx = '0;
  logic [NF-1:0] q_in, bank, m_out, n_out;
  logic [NF-1:0] frc = '0;
  logic [NR-1:0] gnt;
  logic rdata, busy;
`ifdef MN_ARB_VERIFY_EN
  logic err;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [NR:0] exp_q[$];
  logic [NR:0] e;

  mn_ff_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(NF), .IDX_W(IW)) dut (
    .clk(clk), .CLRn(CLRn), .req(req), .op(op), .idx(idx), .q_in(q_in),
    .m_out(m_out), .n_out(n_out), .gnt(gnt), .rdata(rdata), .busy(busy)
`ifdef MN_ARB_VERIFY_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  assign q_in = bank & ~frc;

  always_ff @(negedge clk or posedge CLRn)
    if (CLRn) bank <= '0;
    else for (int i = 0; i < NF; i++)
      case ({m_out[i], n_out[i]})
        2'b00: bank[i] <= ~bank[i];
        2'b01: bank[i] <= 1'b1;
        2'b10: bank[i] <= 1'b0;
        default: ;
      endcase

  always @(negedge clk)
    if (gnt != '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_grant got gnt=%b rdata=%b want no grant", gnt, rdata);
      end else begin
        e = exp_q.pop_front();
        if ({gnt, rdata} !== e) begin
          n_bad++;
          $display("FAIL grant got gnt=%b rdata=%b want gnt=%b rdata=%b", gnt, rdata, e[NR:1], e[0]);
        end
      end
    end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic set_req(int r, logic [1:0] o, int ix);
    op[2*r +: 2] = o;
    idx[IW*r +: IW] = IW'(ix);
    req[r] = 1'b1;
  endtask

  task automatic push(int r, logic rd);
    exp_q.push_back({NR'(1) << r, rd});
  endtask

  task automatic drain();
    int t = 0;
    while ((req != '0 || busy) && t < 100) begin
      @(negedge clk);
      req = req & ~gnt;
      t++;
    end
    chk("drain_done", 32'(req != '0 || busy), 0);
    @(negedge clk);
  endtask

  task automatic one(int r, logic [1:0] o, int ix, logic rd);
    @(negedge clk);
    set_req(r, o, ix);
    push(r, rd);
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 CLRn = 1'b1;
    #1 CLRn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t, g, t1, t2;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m", m_out, 8'hFF);
    chk("rst_n", n_out, 8'hFF);
    CLRn = 1'b0;
    // set flop 3 through requester 0
    @(negedge clk);
    set_req(0, 2'b01, 3);
    push(0, 1'b1);
    @(negedge clk);
    chk("apply_m", m_out, 8'hF7);
    chk("apply_n", n_out, 8'hFF);
    chk("apply_busy", busy, 1);
    @(negedge clk);
    chk("ack_m", m_out, 8'hFF);
    chk("ack_busy", busy, 1);
    req = req & ~gnt;
    drain();
    // abort requester 1 mid-APPLY, then both 0 and 1 request: 0 must win first
    @(negedge clk);
    set_req(1, 2'b01, 4);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    #1 CLRn = 1'b1;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_m", m_out, 8'hFF);
    chk("abort_n", n_out, 8'hFF);
    chk("abort_busy_clr", busy, 0);
    set_req(0, 2'b01, 2);
    push(0, 1'b1);
    push(1, 1'b1);
    CLRn = 1'b0;
    drain();
    // all four toggle flop 5
    do_reset();
    @(negedge clk);
    for (int r = 0; r < NR; r++) set_req(r, 2'b00, 5);
    push(0, 1'b1); push(1, 1'b0); push(2, 1'b1); push(3, 1'b0);
    drain();
    // requester 2 held across two transactions
    @(negedge clk);
    set_req(2, 2'b01, 0);
    push(2, 1'b1);
    push(2, 1'b1);
    t = 0; g = 0; t1 = 0; t2 = 0;
    while (g < 2 && t < 40) begin
      @(negedge clk);
      t++;
      if (gnt[2]) begin
        g++;
        if (g == 1) t1 = t;
        else begin
          t2 = t;
          req[2] = 1'b0;
        end
      end
    end
    chk("hold_grants", g, 2);
    chk("hold_gap", t2 - t1, 4);
    repeat (6) @(negedge clk);
    // set, clear, hold, out-of-range on flop 7 / index 9
    one(1, 2'b01, 7, 1'b1);
    one(1, 2'b10, 7, 1'b0);
    one(1, 2'b11, 7, 1'b0);
    one(1, 2'b01, 9, 1'b0);
    chk("bank_after_oob", q_in, 8'h01);
`ifdef MN_ARB_VERIFY_EN
    chk("err_clean", err, 0);
    frc = 8'h08;
    one(0, 2'b01, 3, 1'b0);
    chk("err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    frc = '0;
    do_reset();
    #1;
    chk("err_reset", err, 0);
`endif
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
